uart_tx_scheduler: RTL

UART_TX_SCHEDULER -- requirements
Module: uart_tx_scheduler

---
 rtl/uart_tx_scheduler.sv | 132 +++++++++++++
 1 files changed

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler that merges several byte-stream requesters onto one UART
// transmitter. Each grant is a bounded burst, and every burst is followed by an idle gap.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | arbitrate among valid requesters; no byte accepted
// XFER  | forward the grantee's bytes to the UART until the burst ends
// GAP   | hold off GAP_CYCLES clocks; new requests are ignored
module uart_tx_scheduler #(
   parameter int NUM_REQ    = 4,
   parameter int MAX_BURST  = 16,
   parameter int GAP_CYCLES = 32
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [NUM_REQ-1:0]         req_valid,
   input  logic [8*NUM_REQ-1:0]       req_data,
   input  logic [NUM_REQ-1:0]         req_last,
   input  logic [NUM_REQ-1:0]         req_parity,
   output logic [NUM_REQ-1:0]         req_ready,
   output logic                       uart_tx_valid,
   output logic [7:0]                 uart_tx_data,
   input  logic                       uart_tx_ready,
   output logic                       uart_parity_en,
   output logic [$clog2(NUM_REQ)-1:0] grant_id,
   output logic                       active
);

   localparam int GW = $clog2(NUM_REQ);
   localparam logic [7:0] BURST_LIM  = 8'(MAX_BURST);
   localparam logic [7:0] STALL_LOAD = 8'(GAP_CYCLES - 1);
   localparam logic [7:0] GAP_LOAD   = 8'(GAP_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      XFER = 2'd1,
      GAP  = 2'd2
   } state_t;

   state_t        state;
   logic [GW-1:0] last_grant;
   logic [7:0]    burst_cnt;
   logic [7:0]    stall_cnt;
   logic [7:0]    gap_cnt;

   logic [GW-1:0] winner;
   logic [GW-1:0] cand;
   logic          any_valid;
   logic          grantee_valid;
   logic          xfer;
   logic          burst_done;

   // Search starts just past the previous grantee and wraps around.
   always_comb begin
      winner    = '0;
      cand      = '0;
      any_valid = 1'b0;
      for (int i = 1; i <= NUM_REQ; i++) begin
         cand = GW'((int'(last_grant) + i) % NUM_REQ);
         if (!any_valid && req_valid[cand]) begin
            any_valid = 1'b1;
            winner    = cand;
         end
      end
   end

   assign grantee_valid = req_valid[grant_id];
   assign xfer          = (state == XFER) && grantee_valid && uart_tx_ready;

   // Stall timeout fires only on a clock where the grantee is not valid, so it never
   // coincides with a transfer.
   assign burst_done = (state == XFER) &&
                       ((xfer && (req_last[grant_id] || (burst_cnt + 8'd1 == BURST_LIM))) ||
                        (!grantee_valid && (stall_cnt == 8'd0)));

   assign uart_tx_valid = !reset && (state == XFER) && grantee_valid;
   assign uart_tx_data  = req_data[{grant_id, 3'b000} +: 8];

   always_comb begin
      req_ready = '0;
      if (!reset && (state == XFER))
         req_ready[grant_id] = uart_tx_ready;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state          <= IDLE;
         grant_id       <= '0;
         last_grant     <= GW'(NUM_REQ - 1);
         burst_cnt      <= 8'd0;
         stall_cnt      <= 8'd0;
         gap_cnt        <= 8'd0;
         uart_parity_en <= 1'b0;
         active         <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (any_valid) begin
                  grant_id       <= winner;
                  uart_parity_en <= req_parity[winner];
                  burst_cnt      <= 8'd0;
                  stall_cnt      <= STALL_LOAD;
                  active         <= 1'b1;
                  state          <= XFER;
               end
            end
            XFER: begin
               if (xfer)
                  burst_cnt <= burst_cnt + 8'd1;
               if (grantee_valid)
                  stall_cnt <= STALL_LOAD;
               else if (stall_cnt != 8'd0)
                  stall_cnt <= stall_cnt - 8'd1;
               if (burst_done) begin
                  last_grant <= grant_id;
                  gap_cnt    <= GAP_LOAD;
                  active     <= 1'b0;
                  state      <= GAP;
               end
            end
            GAP: begin
               if (gap_cnt == 8'd0)
                  state <= IDLE;
               else
                  gap_cnt <= gap_cnt - 8'd1;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
